score_life_ctrl: RTL and testbench

SCORE_LIFE_CTRL -- requirements
Module: score_life_ctrl

---
 rtl/score_life_ctrl_pkg.sv | 25 ++
 rtl/bcd_adder4.sv | 36 +++
 rtl/score_life_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_score_life_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/score_life_ctrl_pkg.sv
// Shared definitions for the score / life controller: game status codes,
// field widths and a constant-only binary-to-BCD helper.
package score_life_ctrl_pkg;

  localparam int GAME_STATUS_BIT_LEN = 3;

  typedef enum logic [GAME_STATUS_BIT_LEN-1:0] {
    GS_PAUSE  = 3'b000,
    GS_RUN    = 3'b001,
    GS_PRERUN = 3'b010,
    GS_OVER   = 3'b011
  } game_status_t;

  localparam int SCORE_W  = 14;
  localparam int BCD_W    = 16;
  localparam int BOMB_MAX = 3;

  // Elaboration-time conversion of a parameter to 4-digit BCD (clamped to 9999).
  function automatic logic [BCD_W-1:0] to_bcd4(input int unsigned v);
    int unsigned x;
    x = (v > 9999) ? 9999 : v;
    return {4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

endpackage

// File: rtl/bcd_adder4.sv
// Adds a binary increment (0..99) to a 4-digit BCD value, saturating at 9999.
module bcd_adder4 (
  input  logic [15:0] bcd_i,
  input  logic [6:0]  inc_i,
  output logic [15:0] sum_o
);

  logic [3:0] inc_tens, inc_ones;
  logic [4:0] d0, d1, d2, d3;
  logic [3:0] s0, s1, s2;
  logic       c0, c1, c2;

  // Digit-by-digit decimal add with carry ripple; overflow of the top digit clamps.
  always_comb begin
    inc_tens = 4'(inc_i / 7'd10);
    inc_ones = 4'(inc_i % 7'd10);

    d0 = {1'b0, bcd_i[3:0]} + {1'b0, inc_ones};
    c0 = (d0 > 5'd9);
    s0 = c0 ? 4'(d0 - 5'd10) : d0[3:0];

    d1 = {1'b0, bcd_i[7:4]} + {1'b0, inc_tens} + {4'd0, c0};
    c1 = (d1 > 5'd9);
    s1 = c1 ? 4'(d1 - 5'd10) : d1[3:0];

    d2 = {1'b0, bcd_i[11:8]} + {4'd0, c1};
    c2 = (d2 > 5'd9);
    s2 = c2 ? 4'(d2 - 5'd10) : d2[3:0];

    d3 = {1'b0, bcd_i[15:12]} + {4'd0, c2};

    if (d3 > 5'd9) sum_o = 16'h9999;
    else           sum_o = {d3[3:0], s2, s1, s0};
  end

endmodule

// File: rtl/score_life_ctrl.sv
// Score, lives, bombs and post-hit invincibility for the game core.
// Collision strobes are latched per frame and evaluated on frame_end_i.
// Optional feature: define SCORE_BCD_EN to keep a BCD copy of the score
// in score_bcd_o (otherwise it is tied to 0 and the adder is not built).
module score_life_ctrl
  import score_life_ctrl_pkg::*;
#(
  parameter int INIT_LIVES    = 3,
  parameter int INVINC_FRAMES = 120,
  parameter int SCORE_HIT     = 10,
  parameter int SCORE_MAX     = 9999
) (
  input  logic                           clk_vga,
  input  logic                           rst_n,
  input  logic [GAME_STATUS_BIT_LEN-1:0] game_status_i,
  input  logic                           frame_end_i,
  input  logic                           crash_me_enemy_i,
  input  logic                           crash_enemy_bullet_i,
  input  logic                           crash_me_bonus_i,
  input  logic                           bomb_use_i,
  output logic [13:0]                    score_o,
  output logic [1:0]                     lives_o,
  output logic [1:0]                     bomb_cnt_o,
  output logic                           invincible_o,
  output logic                           bomb_o,
  output logic                           gameover_o,
  output logic [15:0]                    score_bcd_o
);

  localparam int CNT_W = (INVINC_FRAMES > 0) ? $clog2(INVINC_FRAMES + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_INVINC = 2'd2,
    ST_DEAD   = 2'd3
  } state_t;

  state_t             state_q, state_nxt;
  logic [SCORE_W-1:0] score_q, score_nxt;
  logic [SCORE_W:0]   score_sum;
  logic [1:0]         lives_q, lives_nxt;
  logic [1:0]         bomb_q, bomb_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic               f_me_q, f_eb_q, f_mb_q;
  logic               f_me_nxt, f_eb_nxt, f_mb_nxt;
  logic               bomb_p_q, bomb_p_nxt;
  logic               over_p_q, over_p_nxt;
  logic               invinc_q;
  logic               run, hit_me, hit_eb, hit_mb, bomb_take, bonus;

  // Next-state and counter updates; frame evaluation only while playing and RUN.
  always_comb begin
    state_nxt  = state_q;
    score_nxt  = score_q;
    lives_nxt  = lives_q;
    bomb_nxt   = bomb_q;
    cnt_nxt    = cnt_q;
    bomb_p_nxt = 1'b0;
    over_p_nxt = 1'b0;
    bomb_take  = 1'b0;
    bonus      = 1'b0;

    run       = (game_status_i == GS_RUN);
    hit_me    = f_me_q | crash_me_enemy_i;
    hit_eb    = f_eb_q | crash_enemy_bullet_i;
    hit_mb    = f_mb_q | crash_me_bonus_i;
    score_sum = {1'b0, score_q} + (SCORE_W+1)'(SCORE_HIT);

    // Flags collect collisions over a frame and are consumed at frame end.
    if (frame_end_i) begin
      f_me_nxt = 1'b0;
      f_eb_nxt = 1'b0;
      f_mb_nxt = 1'b0;
    end else begin
      f_me_nxt = f_me_q | (crash_me_enemy_i & run);
      f_eb_nxt = f_eb_q | (crash_enemy_bullet_i & run);
      f_mb_nxt = f_mb_q | (crash_me_bonus_i & run);
    end

    if (game_status_i == GS_PRERUN) begin
      state_nxt = ST_IDLE;
      score_nxt = '0;
      lives_nxt = 2'(INIT_LIVES);
      bomb_nxt  = '0;
      cnt_nxt   = '0;
      f_me_nxt  = 1'b0;
      f_eb_nxt  = 1'b0;
      f_mb_nxt  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (run) state_nxt = ST_PLAY;
        ST_PLAY, ST_INVINC: if (run) begin
          // Simultaneous use and pickup cancel out, even when the stock is full.
          bomb_take  = bomb_use_i && (bomb_q != 2'd0);
          bonus      = frame_end_i && hit_mb;
          bomb_p_nxt = bomb_take;
          if (bomb_take && !bonus)
            bomb_nxt = bomb_q - 2'd1;
          else if (!bomb_take && bonus && (bomb_q != 2'(BOMB_MAX)))
            bomb_nxt = bomb_q + 2'd1;

          if (frame_end_i) begin
            if (hit_eb)
              score_nxt = (score_sum >= (SCORE_W+1)'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX)
                                                                 : score_sum[SCORE_W-1:0];
            if (state_q == ST_INVINC) begin
              if (cnt_q <= CNT_W'(1)) begin
                cnt_nxt   = '0;
                state_nxt = ST_PLAY;
              end else begin
                cnt_nxt = cnt_q - CNT_W'(1);
              end
            end else if (hit_me) begin
              if (lives_q <= 2'd1) begin
                lives_nxt  = 2'd0;
                state_nxt  = ST_DEAD;
                over_p_nxt = 1'b1;
              end else begin
                lives_nxt = lives_q - 2'd1;
                state_nxt = ST_INVINC;
                cnt_nxt   = CNT_W'(INVINC_FRAMES);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers; reset drops any pending frame work.
  always_ff @(posedge clk_vga) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      score_q  <= '0;
      lives_q  <= 2'(INIT_LIVES);
      bomb_q   <= '0;
      cnt_q    <= '0;
      f_me_q   <= 1'b0;
      f_eb_q   <= 1'b0;
      f_mb_q   <= 1'b0;
      bomb_p_q <= 1'b0;
      over_p_q <= 1'b0;
      invinc_q <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      score_q  <= score_nxt;
      lives_q  <= lives_nxt;
      bomb_q   <= bomb_nxt;
      cnt_q    <= cnt_nxt;
      f_me_q   <= f_me_nxt;
      f_eb_q   <= f_eb_nxt;
      f_mb_q   <= f_mb_nxt;
      bomb_p_q <= bomb_p_nxt;
      over_p_q <= over_p_nxt;
      invinc_q <= (state_nxt == ST_INVINC);
    end
  end

  assign score_o      = score_q;
  assign lives_o      = lives_q;
  assign bomb_cnt_o   = bomb_q;
  assign invincible_o = invinc_q;
  assign bomb_o       = bomb_p_q;
  assign gameover_o   = over_p_q;

`ifdef SCORE_BCD_EN
  localparam logic [BCD_W-1:0] SCORE_MAX_BCD = to_bcd4(SCORE_MAX);

  logic [BCD_W-1:0] bcd_q, bcd_sum, bcd_nxt;

  bcd_adder4 u_bcd (
    .bcd_i (bcd_q),
    .inc_i (7'(SCORE_HIT)),
    .sum_o (bcd_sum)
  );

  // The binary score only moves by a reload or one SCORE_HIT step, so follow it.
  always_comb begin
    bcd_nxt = bcd_q;
    if (game_status_i == GS_PRERUN)
      bcd_nxt = '0;
    else if (score_nxt != score_q)
      bcd_nxt = (score_nxt == SCORE_W'(SCORE_MAX)) ? SCORE_MAX_BCD : bcd_sum;
  end

  // BCD score register, same timing as score_q.
  always_ff @(posedge clk_vga) begin
    if (!rst_n) bcd_q <= '0;
    else        bcd_q <= bcd_nxt;
  end

  assign score_bcd_o = bcd_q;
`else
  assign score_bcd_o = '0;
`endif

endmodule

// File: tb/tb_score_life_ctrl.sv
// Bench for score_life_ctrl: directed scenarios followed by random play,
// every cycle compared against an integer-level game model.
module tb_score_life_ctrl;

  localparam logic [2:0] PAUSE = 3'b000, RUN = 3'b001, PRERUN = 3'b010, OVER = 3'b011;
  localparam int INIT_LIVES = 3, INVINC_FRAMES = 120, SCORE_HIT = 10, SCORE_MAX = 9999;

  logic        clk_vga = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  game_status = PAUSE;
  logic        frame_end = 1'b0, c_me = 1'b0, c_eb = 1'b0, c_mb = 1'b0, bomb_use = 1'b0;
  logic [13:0] score_o;
  logic [1:0]  lives_o, bomb_cnt_o;
  logic        invincible_o, bomb_o, gameover_o;
  logic [15:0] score_bcd_o;

  int n_chk = 0, n_err = 0;

  // model state: plain game quantities
  int m_score, m_lives, m_bombs, m_inv;
  bit m_started, m_dead, p_me, p_eb, p_mb, m_bomb_p, m_over_p;

  score_life_ctrl dut (
    .clk_vga              (clk_vga),
    .rst_n                (rst_n),
    .game_status_i        (game_status),
    .frame_end_i          (frame_end),
    .crash_me_enemy_i     (c_me),
    .crash_enemy_bullet_i (c_eb),
    .crash_me_bonus_i     (c_mb),
    .bomb_use_i           (bomb_use),
    .score_o              (score_o),
    .lives_o              (lives_o),
    .bomb_cnt_o           (bomb_cnt_o),
    .invincible_o         (invincible_o),
    .bomb_o               (bomb_o),
    .gameover_o           (gameover_o),
    .score_bcd_o          (score_bcd_o)
  );

  always #5 clk_vga = ~clk_vga;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int dec_to_bcd(input int v);
    return ((v / 1000) << 12) | (((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  // Game rules applied once per clock edge with the inputs held across it.
  task automatic model_step(input bit r, input logic [2:0] st, input bit fe, me, eb, mb, bu);
    bit playing, run, bonus, use_b;
    m_bomb_p = 0;
    m_over_p = 0;
    if (!r || st == PRERUN) begin
      m_score = 0; m_lives = INIT_LIVES; m_bombs = 0; m_inv = 0;
      m_started = 0; m_dead = 0; p_me = 0; p_eb = 0; p_mb = 0;
      return;
    end
    run     = (st == RUN);
    playing = m_started && !m_dead;
    if (!m_started && !m_dead && run) m_started = 1;
    if (playing && run) begin
      bonus = fe && (p_mb || mb);
      use_b = bu && (m_bombs > 0);
      m_bomb_p = use_b;
      if (use_b && bonus) ;
      else if (use_b) m_bombs--;
      else if (bonus && m_bombs < 3) m_bombs++;
      if (fe) begin
        if (p_eb || eb) m_score = (m_score + SCORE_HIT > SCORE_MAX) ? SCORE_MAX : m_score + SCORE_HIT;
        if (m_inv > 0) m_inv--;
        else if (p_me || me) begin
          m_lives--;
          if (m_lives == 0) begin m_dead = 1; m_over_p = 1; end
          else m_inv = INVINC_FRAMES;
        end
      end
    end
    if (fe) begin p_me = 0; p_eb = 0; p_mb = 0; end
    else begin p_me |= me && run; p_eb |= eb && run; p_mb |= mb && run; end
  endtask

  task automatic check_all();
    int exp_bcd;
`ifdef SCORE_BCD_EN
    exp_bcd = dec_to_bcd(m_score);
`else
    exp_bcd = 0;
`endif
    chk("score", int'(score_o), m_score);
    chk("lives", int'(lives_o), m_lives);
    chk("bombs", int'(bomb_cnt_o), m_bombs);
    chk("invincible", int'(invincible_o), int'(m_inv > 0));
    chk("bomb_o", int'(bomb_o), int'(m_bomb_p));
    chk("gameover", int'(gameover_o), int'(m_over_p));
    chk("score_bcd", int'(score_bcd_o), exp_bcd);
  endtask

  task automatic tick(input bit r, input logic [2:0] st, input bit fe, me, eb, mb, bu);
    @(negedge clk_vga);
    rst_n = r; game_status = st; frame_end = fe;
    c_me = me; c_eb = eb; c_mb = mb; bomb_use = bu;
    @(posedge clk_vga);
    model_step(r, st, fe, me, eb, mb, bu);
    #1;
    check_all();
  endtask

  initial begin
    // reset with every strobe active
    repeat (3) tick(0, RUN, 1, 1, 1, 1, 1);
    chk("rst_score", int'(score_o), 0);
    chk("rst_lives", int'(lives_o), INIT_LIVES);
    chk("rst_invinc", int'(invincible_o), 0);

    // 500 bullet strobes in one frame score once
    tick(1, PRERUN, 0, 0, 0, 0, 0);
    tick(1, RUN, 0, 0, 0, 0, 0);
    repeat (500) tick(1, RUN, 0, 0, 1, 0, 0);
    tick(1, RUN, 1, 0, 0, 0, 0);
    chk("s500_score", int'(score_o), 10);

    // hit, then 120 invincible frames of hits
    tick(1, RUN, 0, 1, 0, 0, 0);
    tick(1, RUN, 1, 0, 0, 0, 0);
    chk("s31_lives", int'(lives_o), 2);
    chk("s31_inv", int'(invincible_o), 1);
    for (int i = 0; i < INVINC_FRAMES; i++) begin
      tick(1, RUN, 1, 1, 0, 0, 0);
      if (i == INVINC_FRAMES - 2) chk("s31_inv_hold", int'(invincible_o), 1);
    end
    chk("s31_inv_end", int'(invincible_o), 0);
    chk("s31_lives_end", int'(lives_o), 2);

    // down to one life, then a fatal frame that also scores
    tick(1, RUN, 1, 1, 0, 0, 0);
    repeat (INVINC_FRAMES) tick(1, RUN, 1, 0, 0, 0, 0);
    chk("s32_lives1", int'(lives_o), 1);
    tick(1, RUN, 0, 1, 1, 0, 0);
    tick(1, RUN, 1, 0, 0, 0, 0);
    chk("s32_lives0", int'(lives_o), 0);
    chk("s32_score", int'(score_o), 20);
    chk("s32_over", int'(gameover_o), 1);
    tick(1, RUN, 1, 1, 1, 1, 1);
    chk("s32_over_pulse", int'(gameover_o), 0);
    chk("s32_dead_score", int'(score_o), 20);

    // score saturation
    tick(1, PRERUN, 0, 0, 0, 0, 0);
    tick(1, RUN, 0, 0, 0, 0, 0);
    repeat (999) tick(1, RUN, 1, 0, 1, 0, 0);
    chk("s33_9990", int'(score_o), 9990);
    tick(1, RUN, 1, 0, 1, 0, 0);
    chk("s33_sat", int'(score_o), 9999);
    tick(1, RUN, 1, 0, 1, 0, 0);
    chk("s33_sat2", int'(score_o), 9999);

    // bomb stock saturation and use
    repeat (4) tick(1, RUN, 1, 0, 0, 1, 0);
    chk("s34_bombs3", int'(bomb_cnt_o), 3);
    tick(1, RUN, 0, 0, 0, 0, 1);
    chk("s34_bombs2", int'(bomb_cnt_o), 2);
    chk("s34_bomb_o", int'(bomb_o), 1);
    tick(1, RUN, 0, 0, 0, 0, 0);
    chk("s34_bomb_pulse", int'(bomb_o), 0);
    tick(1, RUN, 0, 0, 0, 0, 1);
    tick(1, RUN, 0, 0, 0, 0, 1);
    tick(1, RUN, 0, 0, 0, 0, 1);
    chk("s34_empty_bomb_o", int'(bomb_o), 0);
    chk("s34_empty", int'(bomb_cnt_o), 0);

    // reset mid-invincibility with pending flags
    tick(1, RUN, 1, 1, 0, 1, 0);
    tick(1, RUN, 0, 1, 1, 1, 0);
    tick(0, RUN, 0, 1, 1, 1, 1);
    chk("s35_inv", int'(invincible_o), 0);
    chk("s35_score", int'(score_o), 0);
    chk("s35_over", int'(gameover_o), 0);
    chk("s35_bomb_o", int'(bomb_o), 0);
    tick(1, RUN, 0, 0, 0, 0, 0);
    tick(1, RUN, 1, 0, 0, 0, 0);
    chk("s35_flags_gone", int'(score_o), 0);

    // random play
    for (int i = 0; i < 6000; i++) begin
      int sel;
      logic [2:0] st;
      sel = $urandom_range(99, 0);
      st  = (sel < 88) ? RUN : (sel < 94) ? PAUSE : (sel < 97) ? OVER : PRERUN;
      tick(($urandom_range(199, 0) != 0), st, ($urandom_range(3, 0) == 0),
           ($urandom_range(11, 0) == 0), ($urandom_range(5, 0) == 0),
           ($urandom_range(9, 0) == 0), ($urandom_range(7, 0) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
